tmr_resync_controller: RTL and testbench

//  Sequences recovery of one faulty core in the triple-core group after the voter flags a single-core

---
 rtl/tmr_resync_controller_pkg.sv | 32 +++
 rtl/tmr_resync_controller_if.sv | 31 +++
 rtl/tmr_resync_controller_sat.sv | 17 +
 rtl/tmr_resync_controller.sv | 126 ++++++++++++
 tb/tb_tmr_resync_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tmr_resync_controller_pkg.sv
// tmr_resync_controller_pkg: FSM states, vote constants and voter-decoding helpers
package tmr_resync_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIRM,
        S_HOLD,
        S_COPY,
        S_PC_SYNC,
        S_RELEASE,
        S_FAULT
    } state_t;

    localparam logic [2:0] VOTE_OK = 3'b000;
    localparam logic [1:0] CORE_A  = 2'd0;
    localparam logic [1:0] CORE_B  = 2'd1;
    localparam logic [1:0] CORE_C  = 2'd2;

    function automatic logic is_multi(input logic [2:0] v);
        return (v & (v - 3'd1)) != 3'd0;
    endfunction

    function automatic logic is_onehot(input logic [2:0] v);
        return v != VOTE_OK && !is_multi(v);
    endfunction

    // Lowest-indexed healthy core donates state.
    function automatic logic [1:0] donor_of(input logic [2:0] v);
        return v[0] ? CORE_B : CORE_A;
    endfunction

endpackage

// File: rtl/tmr_resync_controller_if.sv
// tmr_resync_controller_if: voter inputs and register-file/PC copy bus of the resync controller
interface tmr_resync_controller_if #(parameter int CNT_W = 8);

    logic [2:0]       voter_state;
    logic             lockstep_busy;
    logic             core_hold;
    logic [1:0]       src_sel;
    logic [4:0]       rf_rd_addr;
    logic [31:0]      rf_rd_data;
    logic [2:0]       rf_wr_en;
    logic [4:0]       rf_wr_addr;
    logic [31:0]      rf_wr_data;
    logic [31:0]      pc_src;
    logic [2:0]       pc_load;
    logic             resync_done;
    logic             resync_fault;
    logic [CNT_W-1:0] fault_count;

    modport master (
        input  voter_state, lockstep_busy, rf_rd_data, pc_src,
        output core_hold, src_sel, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
               pc_load, resync_done, resync_fault, fault_count
    );

    modport slave (
        output voter_state, lockstep_busy, rf_rd_data, pc_src,
        input  core_hold, src_sel, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
               pc_load, resync_done, resync_fault, fault_count
    );

endinterface

// File: rtl/tmr_resync_controller_sat.sv
// tmr_resync_controller_sat: saturating up-counter for completed resyncs
module tmr_resync_controller_sat #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_in)
        if (!rst_in)
            q <= '0;
        else if (inc && q != '1)
            q <= q + 1'b1;

endmodule

// File: rtl/tmr_resync_controller.sv
// tmr_resync_controller: confirms a single-core mismatch, holds the cores and copies GPRs then PC
// from a healthy donor into the faulty core.
module tmr_resync_controller
    import tmr_resync_controller_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 2,
    parameter int DRAIN_CYCLES   = 1,
    parameter int NUM_REGS       = 32,
    parameter int CNT_W          = 8
) (
    input logic                     clk,
    input logic                     rst_in,
    tmr_resync_controller_if.master bus
);

    localparam int              PW         = $clog2(NUM_REGS) + 1;
    localparam logic [7:0]      CONF_LAST  = 8'(CONFIRM_CYCLES - 1);
    localparam logic [7:0]      DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [PW-1:0]   PTR_END    = PW'(NUM_REGS);

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic [2:0]    target, target_n;
    logic [1:0]    src, src_n;
    logic [PW-1:0] ptr, ptr_n;
    logic          hold, hold_n, fault, wr_valid;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [2:0]    v;
    logic          busy;

    assign v    = bus.voter_state;
    assign busy = bus.lockstep_busy;

    // target doubles as the confirm candidate; it is frozen once HOLD is entered.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        target_n = target;
        src_n    = src;
        ptr_n    = ptr;
        case (state)
            S_IDLE:
                if (!busy && is_multi(v))
                    state_n = S_FAULT;
                else if (!busy && is_onehot(v)) begin
                    state_n  = CONFIRM_CYCLES <= 1 ? S_HOLD : S_CONFIRM;
                    cnt_n    = CONFIRM_CYCLES <= 1 ? 8'd0 : 8'd1;
                    target_n = v;
                    src_n    = donor_of(v);
                end
            S_CONFIRM:
                if (busy || v == VOTE_OK)
                    state_n = S_IDLE;
                else if (is_multi(v))
                    state_n = S_FAULT;
                else if (v != target) begin
                    target_n = v;
                    src_n    = donor_of(v);
                    cnt_n    = 8'd1;
                end else if (cnt >= CONF_LAST) begin
                    state_n = S_HOLD;
                    cnt_n   = 8'd0;
                end else
                    cnt_n = cnt + 8'd1;
            S_HOLD:
                if (cnt >= DRAIN_LAST) begin
                    state_n = S_COPY;
                    ptr_n   = PW'(1);
                end else
                    cnt_n = cnt + 8'd1;
            S_COPY: begin
                ptr_n   = ptr == PTR_END ? '0 : ptr + 1'b1;
                state_n = ptr == PTR_END ? S_PC_SYNC : S_COPY;
            end
            S_PC_SYNC: state_n = S_RELEASE;
            S_RELEASE: state_n = S_IDLE;
            S_FAULT:   state_n = S_FAULT;
            default:   state_n = S_IDLE;
        endcase
        hold_n = state_n inside {S_HOLD, S_COPY, S_PC_SYNC, S_FAULT};
    end

    always_ff @(posedge clk or negedge rst_in)
        if (!rst_in) begin
            state    <= S_IDLE;
            cnt      <= '0;
            target   <= '0;
            src      <= '0;
            ptr      <= '0;
            hold     <= 1'b0;
            fault    <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            target   <= target_n;
            src      <= src_n;
            ptr      <= ptr_n;
            hold     <= hold_n;
            fault    <= fault | (state_n == S_FAULT);
            wr_valid <= state == S_COPY && ptr != PTR_END;
            wr_addr  <= bus.rf_rd_addr;
            wr_data  <= bus.rf_rd_data;
        end

    assign bus.core_hold    = hold;
    assign bus.src_sel      = src;
    assign bus.rf_rd_addr   = 5'(ptr);
    assign bus.rf_wr_en     = wr_valid ? target : 3'b000;
    assign bus.rf_wr_addr   = wr_addr;
    assign bus.rf_wr_data   = state == S_PC_SYNC ? bus.pc_src : wr_data;
    assign bus.pc_load      = state == S_PC_SYNC ? target : 3'b000;
    assign bus.resync_done  = state == S_RELEASE;
    assign bus.resync_fault = fault;

    tmr_resync_controller_sat #(.W(CNT_W)) u_sat (
        .clk    (clk),
        .rst_in (rst_in),
        .inc    (state == S_RELEASE),
        .q      (bus.fault_count)
    );

endmodule

// File: tb/tb_tmr_resync_controller.sv
// tb_tmr_resync_controller: vector table for confirm/fault decisions plus scoreboarded resync sequences
module tb_tmr_resync_controller;

    typedef struct packed {
        logic [2:0]  en;
        logic [2:0]  pl;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [2:0] v;
        logic       busy;
        logic       hold;
        logic       fault;
    } vec_t;

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    int checks = 0;
    int failures = 0;
    int exp_fc = 0;
    wr_t sb[$];
    logic [31:0] rf [4][32];
    logic [31:0] pc [4];
    vec_t vecs [14];

    tmr_resync_controller_if bus ();

    tmr_resync_controller dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.rf_rd_data = rf[bus.src_sel][bus.rf_rd_addr];
    assign bus.pc_src     = pc[bus.src_sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // One clock; sample at the falling edge and compare any write strobe against the scoreboard.
    task automatic cyc();
        wr_t e;
        @(negedge clk);
        if (bus.rf_wr_en != 3'b000 || bus.pc_load != 3'b000) begin
            chk("wr_pc_exclusive", 32'((|bus.rf_wr_en) && (|bus.pc_load)), 32'd0);
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rf_wr_en", 32'(bus.rf_wr_en), 32'(e.en));
                chk("pc_load", 32'(bus.pc_load), 32'(e.pl));
                if (e.en != 3'b000)
                    chk("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(e.addr));
                chk("rf_wr_data", bus.rf_wr_data, e.data);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in = 1'b0;
        bus.voter_state = 3'b000;
        bus.lockstep_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        sb.delete();
        exp_fc = 0;
    endtask

    task automatic push_exp(input logic [2:0] v);
        int d;
        d = v[0] ? 1 : 0;
        for (int a = 1; a < 32; a++)
            sb.push_back('{en: v, pl: 3'b000, addr: 5'(a), data: rf[d][a]});
        sb.push_back('{en: 3'b000, pl: v, addr: 5'd0, data: pc[d]});
    endtask

    task automatic do_resync(input logic [2:0] v, input int busy_cyc);
        int n;
        int lat;
        push_exp(v);
        bus.voter_state = v;
        bus.lockstep_busy = busy_cyc > 0;
        for (int i = 0; i < busy_cyc; i++) begin
            cyc();
            chk("busy_defer_hold", 32'(bus.core_hold), 32'd0);
        end
        bus.lockstep_busy = 1'b0;
        n = 0;
        while (!bus.core_hold && n < 10) begin
            cyc();
            n++;
        end
        chk("confirm_cycles", n, 2);
        chk("src_sel", 32'(bus.src_sel), v[0] ? 32'd1 : 32'd0);
        bus.voter_state = 3'b000;
        lat = 1;
        while (!bus.resync_done && lat < 100) begin
            cyc();
            lat++;
        end
        chk("latency", lat, 35);
        chk("hold_at_done", 32'(bus.core_hold), 32'd0);
        chk("sb_drained", sb.size(), 0);
        exp_fc = exp_fc == 255 ? 255 : exp_fc + 1;
        cyc();
        chk("fault_count", 32'(bus.fault_count), exp_fc);
        chk("done_single_pulse", 32'(bus.resync_done), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int c = 0; c < 4; c++) begin
            pc[c] = c < 3 ? $urandom : 32'd0;
            for (int a = 0; a < 32; a++)
                rf[c][a] = c < 3 ? $urandom : 32'd0;
        end
        vecs = '{
            '{3'b010, 1'b0, 1'b0, 1'b0}, '{3'b000, 1'b0, 1'b0, 1'b0},
            '{3'b000, 1'b0, 1'b0, 1'b0}, '{3'b100, 1'b1, 1'b0, 1'b0},
            '{3'b100, 1'b1, 1'b0, 1'b0}, '{3'b100, 1'b0, 1'b0, 1'b0},
            '{3'b010, 1'b0, 1'b0, 1'b0}, '{3'b010, 1'b1, 1'b0, 1'b0},
            '{3'b010, 1'b0, 1'b0, 1'b0}, '{3'b001, 1'b0, 1'b0, 1'b0},
            '{3'b000, 1'b0, 1'b0, 1'b0}, '{3'b100, 1'b0, 1'b0, 1'b0},
            '{3'b110, 1'b0, 1'b1, 1'b1}, '{3'b000, 1'b0, 1'b1, 1'b1}
        };
        bus.voter_state = 3'b000;
        bus.lockstep_busy = 1'b0;
        do_reset();
        cyc();
        chk("rst_core_hold", 32'(bus.core_hold), 32'd0);
        chk("rst_resync_done", 32'(bus.resync_done), 32'd0);
        chk("rst_resync_fault", 32'(bus.resync_fault), 32'd0);
        chk("rst_fault_count", 32'(bus.fault_count), 32'd0);
        chk("rst_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
        chk("rst_src_sel", 32'(bus.src_sel), 32'd0);
        chk("rst_rf_rd_addr", 32'(bus.rf_rd_addr), 32'd0);

        do_resync(3'b001, 0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            bus.voter_state = vecs[i].v;
            bus.lockstep_busy = vecs[i].busy;
            cyc();
            chk($sformatf("vec%0d_hold", i), 32'(bus.core_hold), 32'(vecs[i].hold));
            chk($sformatf("vec%0d_fault", i), 32'(bus.resync_fault), 32'(vecs[i].fault));
        end
        chk("vec_fault_count", 32'(bus.fault_count), 32'd0);

        do_reset();
        bus.voter_state = 3'b011;
        cyc();
        bus.voter_state = 3'b000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_fault_hold", 32'(bus.core_hold), 32'd1);
            chk("idle_fault_sticky", 32'(bus.resync_fault), 32'd1);
        end
        do_reset();
        cyc();
        chk("fault_cleared_by_reset", 32'(bus.resync_fault), 32'd0);

        push_exp(3'b010);
        bus.voter_state = 3'b010;
        n = 0;
        while (!bus.core_hold && n < 10) begin
            cyc();
            n++;
        end
        bus.voter_state = 3'b000;
        n = 0;
        while (bus.rf_rd_addr != 5'd10 && n < 40) begin
            cyc();
            n++;
        end
        chk("reached_rd_ptr_10", 32'(bus.rf_rd_addr), 32'd10);
        #2 rst_in = 1'b0;
        #1;
        chk("async_rst_hold", 32'(bus.core_hold), 32'd0);
        chk("async_rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("async_rst_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
        chk("async_rst_src_sel", 32'(bus.src_sel), 32'd0);
        sb.delete();
        exp_fc = 0;
        @(negedge clk);
        rst_in = 1'b1;
        repeat (2) cyc();
        chk("post_rst_idle_hold", 32'(bus.core_hold), 32'd0);
        do_resync(3'b100, 0);

        do_resync(3'b100, 5);

        do_reset();
        for (int i = 0; i < 255; i++)
            do_resync(3'b001 << $urandom_range(0, 2), 0);
        chk("fault_count_full", 32'(bus.fault_count), 32'hFF);
        do_resync(3'b010, 0);
        chk("fault_count_saturated", 32'(bus.fault_count), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
